core_mul_unit: RTL
==================

Name: core_mul_unit

Overview:
- Iterative multiply/multiply-accumulate execution unit for the ARM core.
- Consumes the `mul_decode` bundle produced by the multiply decoder, plus operand values read from the register file: Rm, Rs and the accumulate registers `r_add_lo` / `r_add_hi`.
- Produces a 32-bit result (MUL/MLA) or a 64-bit result (UMULL/UMLAL/SMULL/SMLAL), with N/Z flags, after a fixed multi-cycle latency.
- Sits in the execute stage; the control unit stalls on `busy`.

Parameters:
- STEP_BITS, 2, multiplier bits retired per iteration cycle. Legal values are 1, 2 and 4. Iteration count N = 32/STEP_BITS.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  accept a new operation this cycle; sampled only when `busy`=0
- flush  in  1  pipeline flush; aborts any in-flight operation
- decode  in  mul_decode  from the decoder; uses `add`, `long_mul` and `signed_mul`
- a  in  32  Rm value (multiplicand)
- b  in  32  Rs value (multiplier)
- c_lo  in  32  value of `r_add_lo` (Rn for MLA, RdLo for long accumulate)
- c_hi  in  32  value of `r_add_hi` (RdHi for long accumulate)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when results are valid
- q_lo  out  32  result low word (Rd for short ops)
- q_hi  out  32  result high word; long ops only
- n  out  1  negative flag of the result
- z  out  1  zero flag of the result

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = IDLE.
  - busy, done, n, z, q_lo, q_hi all 0.
- States: IDLE, ITER, FIX.
- IDLE:
  - When start=1 and flush=0: latch a, b, c_lo, c_hi, add, long_mul, signed_mul; clear the 64-bit accumulator P; set iteration count = 0; go to ITER. busy=1 from the next cycle.
- ITER:
  - Each cycle: P += ({32'b0, a} * b[STEP_BITS-1:0]) << (count*STEP_BITS).
  - b shifts right by STEP_BITS; count increments.
  - After N cycles go to FIX.
  - The product is the unsigned 64-bit product of the raw 32-bit operands.
- FIX (1 cycle):
  - If signed_mul: subtract (a[31] ? b<<32 : 0) and (b[31] ? a<<32 : 0), mod 2^64.
  - If add: add {c_hi, c_lo} for long ops, or {32'b0, c_lo} for short ops.
  - Register the result into q_lo/q_hi.
  - Short ops force q_hi = 0. `signed_mul` is ignored for short ops; the low 32 bits are identical either way.
  - Compute flags:
    - long: n = P[63], z = (P[63:0] == 0).
    - short: n = P[31], z = (P[31:0] == 0).
  - Assert done=1 in the following cycle, return to IDLE, busy=0.
- Latency: start sampled at edge T gives done=1 in cycle T+N+2 (T+18 for STEP_BITS=2). Fixed and data-independent.
- Outputs: q_lo, q_hi, n and z hold their values until the next operation's FIX cycle.
- Busy and start interaction:
  - start while busy=1 is ignored, with no effect on state.
  - start in the same cycle done=1 is accepted; back-to-back operation is allowed.
- Flush:
  - flush=1 in any state returns the unit to IDLE next cycle with busy=0.
  - done is suppressed and q/n/z are left unchanged.
  - flush together with start in IDLE: flush wins and the operation is not accepted.
- Width and overflow:
  - All accumulation is mod 2^64, with no overflow reporting.
  - C and V flags are not produced; the flag unit preserves them per ARMv4.
- Reset mid-operation: asynchronous return to the reset values; no partial result is visible.

Decomposition:
- Shared package (uarch):
  - `mul_decode` (existing).
  - `mul_state` enum {IDLE, ITER, FIX}.
  - constant MUL_ITERS = 32/STEP_BITS, where the default is derived.
- One sub-module: `core_mul_step`, a combinational partial-product adder that takes P, a, the multiplier slice and the shift and returns the next P. It is instantiated once inside `core_mul_unit`.

Test Plan:
- MUL a=3, b=5, add=0, long=0 -> done at T+18; q_lo=0x0000000F, q_hi=0, n=0, z=0.
- UMULL a=b=0xFFFFFFFF -> q_hi=0xFFFFFFFE, q_lo=0x00000001, n=1, z=0; SMULL same operands -> q_hi=0, q_lo=1, n=0.
- SMLAL a=0xFFFFFFFE (-2), b=3, c_hi=0, c_lo=5 -> q_hi=q_lo=0xFFFFFFFF, n=1, z=0.
- MUL a=0x80000000, b=2 -> q_lo=0, z=1, n=0; MLA a=b=0x10000, c_lo=7 -> q_lo=7, z=0.
- start pulsed again at T+5 while busy -> ignored, first result unchanged; start at the done cycle -> second done exactly 18 cycles later.
- flush at T+8 -> busy=0 at T+9, no done pulse, q/n/z retain previous values; rst_n=0 at T+4 -> all outputs 0 immediately.

Source files
------------

// File: rtl/core_mul_unit_pkg.sv
// Shared multiply-unit types: decoder bundle, FSM states and iteration constants.
package core_mul_unit_pkg;

   localparam int unsigned MUL_STEP_BITS = 2;
   localparam int unsigned MUL_ITERS     = 32 / MUL_STEP_BITS;

   typedef struct packed {
      logic add;
      logic long_mul;
      logic signed_mul;
   } mul_decode;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIX
   } mul_state;

endpackage

// File: rtl/core_mul_step.sv
// Combinational partial-product adder: adds one shifted multiplier slice times a into P.
module core_mul_step
   import core_mul_unit_pkg::*;
#(
   parameter int unsigned STEP_BITS = MUL_STEP_BITS
) (
   input  logic [63:0]          p,
   input  logic [31:0]          a,
   input  logic [STEP_BITS-1:0] slice,
   input  logic [5:0]           shamt,
   output logic [63:0]          p_next_c
);

   logic [63:0] pp;

   always_comb begin
      pp       = 64'(a) * 64'(slice);
      p_next_c = p + (pp << shamt);
   end

endmodule

// File: rtl/core_mul_unit.sv
// Iterative MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit; retires STEP_BITS multiplier bits per cycle.
module core_mul_unit
   import core_mul_unit_pkg::*;
#(
   parameter int unsigned STEP_BITS = MUL_STEP_BITS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        flush,
   input  mul_decode   decode,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c_lo,
   input  logic [31:0] c_hi,
   output logic        busy,
   output logic        done,
   output logic [31:0] q_lo,
   output logic [31:0] q_hi,
   output logic        n,
   output logic        z
);

   localparam int unsigned ITERS = 32 / STEP_BITS;
   localparam int unsigned CNT_W = 6;

   mul_state         state_q, state_d;
   mul_decode        op_q, op_d;
   logic [31:0]      a_q, a_d, b_q, b_d, mpl_q, mpl_d;
   logic [31:0]      c_lo_q, c_lo_d, c_hi_q, c_hi_d;
   logic [63:0]      p_q, p_d, p_step_c, res;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_d, done_d, n_d, z_d;
   logic [31:0]      q_lo_d, q_hi_d;

   core_mul_step #(.STEP_BITS(STEP_BITS)) u_step (
      .p        (p_q),
      .a        (a_q),
      .slice    (mpl_q[STEP_BITS-1:0]),
      .shamt    (6'(cnt_q * STEP_BITS)),
      .p_next_c (p_step_c)
   );

   // Next-state, datapath and output-register logic
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      mpl_d   = mpl_q;
      c_lo_d  = c_lo_q;
      c_hi_d  = c_hi_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      busy_d  = busy;
      done_d  = 1'b0;
      q_lo_d  = q_lo;
      q_hi_d  = q_hi;
      n_d     = n;
      z_d     = z;

      // Signed correction only matters for the high word, so short ops skip it
      res = p_q;
      if (op_q.long_mul && op_q.signed_mul) begin
         if (a_q[31]) res = res - {b_q, 32'b0};
         if (b_q[31]) res = res - {a_q, 32'b0};
      end
      if (op_q.add) res = res + (op_q.long_mul ? {c_hi_q, c_lo_q} : {32'b0, c_lo_q});

      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               op_d    = decode;
               a_d     = a;
               b_d     = b;
               mpl_d   = b;
               c_lo_d  = c_lo;
               c_hi_d  = c_hi;
               p_d     = 64'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ITER;
            end
         end
         ITER: begin
            p_d   = p_step_c;
            mpl_d = mpl_q >> STEP_BITS;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
         end
         FIX: begin
            q_lo_d = res[31:0];
            if (op_q.long_mul) begin
               q_hi_d = res[63:32];
               n_d    = res[63];
               z_d    = (res == 64'b0);
            end else begin
               q_hi_d = 32'b0;
               n_d    = res[31];
               z_d    = (res[31:0] == 32'b0);
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Flush abandons the operation and leaves the visible results untouched
      if (flush) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         q_lo_d  = q_lo;
         q_hi_d  = q_hi;
         n_d     = n;
         z_d     = z;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mpl_q   <= '0;
         c_lo_q  <= '0;
         c_hi_q  <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         q_lo    <= '0;
         q_hi    <= '0;
         n       <= 1'b0;
         z       <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mpl_q   <= mpl_d;
         c_lo_q  <= c_lo_d;
         c_hi_q  <= c_hi_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         busy    <= busy_d;
         done    <= done_d;
         q_lo    <= q_lo_d;
         q_hi    <= q_hi_d;
         n       <= n_d;
         z       <= z_d;
      end
   end

endmodule
